// File: rtl/idct_1d_engine.sv
// 8-point 1-D inverse DCT engine.
// Loads X[0..7] over a valid/ready handshake, then produces x[0..7] one sample at a
// time with a single multiply-accumulate unit, holding each sample until accepted.
module idct_1d_engine (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] coeff_in,
   input  logic        coeff_valid,
   output logic        coeff_ready,
   output logic [15:0] sample_out,
   output logic [2:0]  sample_idx,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {StIdle, StLoad, StMac, StOut, StDone} state_e;

   state_e              state_q, state_d;
   logic [2:0]          k_q, k_d;
   logic [2:0]          n_q, n_d;
   // 0..7 accumulate X[k]*C[n][k]; 8 rounds and registers the sample.
   logic [3:0]          cnt_q, cnt_d;
   logic signed [34:0]  acc_q, acc_d;
   logic [7:0][15:0]    x_q, x_d;
   logic [15:0]         sample_q, sample_d;
   logic [2:0]          idx_q, idx_d;
   logic                ov_q, ov_d;

   logic signed [15:0]  coef_w;
   logic signed [31:0]  prod_w;
   logic signed [34:0]  rnd_w;
   logic signed [20:0]  shf_w;
   logic [15:0]         sat_w;

   // C[n][k] = round(8192 * c(k) * cos((2n+1)k*pi/16)), folded onto one quarter wave.
   function automatic logic signed [15:0] coef(input logic [2:0] n, input logic [2:0] k);
      logic [6:0]  p;
      logic [4:0]  m;
      logic [4:0]  idx;
      logic        neg;
      logic [15:0] mag;
      p = 7'({n, 1'b1}) * 7'(k);
      m = p[4:0];
      if (m <= 5'd8) begin
         idx = m;
         neg = 1'b0;
      end else if (m <= 5'd16) begin
         idx = 5'd16 - m;
         neg = 1'b1;
      end else if (m <= 5'd24) begin
         idx = m - 5'd16;
         neg = 1'b1;
      end else begin
         idx = 5'd0 - m;
         neg = 1'b0;
      end
      case (idx)
         5'd1:    mag = 16'd8035;
         5'd2:    mag = 16'd7568;
         5'd3:    mag = 16'd6811;
         5'd4:    mag = 16'd5793;
         5'd5:    mag = 16'd4551;
         5'd6:    mag = 16'd3135;
         5'd7:    mag = 16'd1598;
         5'd8:    mag = 16'd0;
         default: mag = 16'd8192;
      endcase
      if (k == 3'd0) begin
         coef = 16'sd5793;
      end else if (neg) begin
         coef = -$signed(mag);
      end else begin
         coef = $signed(mag);
      end
   endfunction

   // MAC datapath: product, round-half-up, arithmetic shift and 16-bit saturation.
   always_comb begin
      coef_w = coef(n_q, cnt_q[2:0]);
      prod_w = $signed(x_q[cnt_q[2:0]]) * coef_w;
      rnd_w  = acc_q + 35'sd8192;
      shf_w  = rnd_w[34:14];
      if (shf_w > 21'sd32767) begin
         sat_w = 16'h7fff;
      end else if (shf_w < -21'sd32768) begin
         sat_w = 16'h8000;
      end else begin
         sat_w = shf_w[15:0];
      end
   end

   // Next-state logic for the FSM, counters, coefficient registers and output register.
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      n_d      = n_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      x_d      = x_q;
      sample_d = sample_q;
      idx_d    = idx_q;
      ov_d     = ov_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               k_d     = 3'd0;
               n_d     = 3'd0;
            end
         end
         StLoad: begin
            if (coeff_valid) begin
               x_d[k_q] = coeff_in;
               k_d      = k_q + 3'd1;
               if (k_q == 3'd7) begin
                  state_d = StMac;
                  cnt_d   = 4'd0;
                  acc_d   = '0;
               end
            end
         end
         StMac: begin
            if (cnt_q[3]) begin
               sample_d = sat_w;
               idx_d    = n_q;
               ov_d     = 1'b1;
               state_d  = StOut;
            end else begin
               acc_d = acc_q + {{3{prod_w[31]}}, prod_w};
               cnt_d = cnt_q + 4'd1;
            end
         end
         StOut: begin
            if (out_ready) begin
               ov_d = 1'b0;
               if (n_q == 3'd7) begin
                  state_d = StDone;
               end else begin
                  n_d     = n_q + 3'd1;
                  state_d = StMac;
                  cnt_d   = 4'd0;
                  acc_d   = '0;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         k_q      <= 3'd0;
         n_q      <= 3'd0;
         cnt_q    <= 4'd0;
         acc_q    <= '0;
         x_q      <= '0;
         sample_q <= 16'd0;
         idx_q    <= 3'd0;
         ov_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         n_q      <= n_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         x_q      <= x_d;
         sample_q <= sample_d;
         idx_q    <= idx_d;
         ov_q     <= ov_d;
      end
   end

   // Status outputs decoded from the state register.
   always_comb begin
      coeff_ready = (state_q == StLoad);
      busy        = (state_q != StIdle);
      done        = (state_q == StDone);
      sample_out  = sample_q;
      sample_idx  = idx_q;
      out_valid   = ov_q;
   end

endmodule

// File: tb/tb_idct_1d_engine.sv
// Self-checking bench for idct_1d_engine: table of blocks plus hand-written corner cases,
// expected samples queued from a fixed-point reference model when each block is driven.
module tb_idct_1d_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] coeff_in;
   logic        coeff_valid;
   logic        coeff_ready;
   logic [15:0] sample_out;
   logic [2:0]  sample_idx;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;

   idct_1d_engine dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .coeff_in    (coeff_in),
      .coeff_valid (coeff_valid),
      .coeff_ready (coeff_ready),
      .sample_out  (sample_out),
      .sample_idx  (sample_idx),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0][15:0] x;
      int               gap;   // percent of LOAD cycles with coeff_valid low
      int               mode;  // 0 model, 1 all samples = expv, 2 sample 0 = expv
      int               expv;
   } vec_t;

   vec_t tbl[6];
   int   ctab[8][8];
   int   q_val[$];
   int   q_idx[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   acc_edge = 0;
   int   k_acc = 0;
   int   stall_pct = 0;
   int   bp_target = 3;
   int   bp_cnt = 0;
   logic prev_ov = 1'b0;
   logic prev_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int ref_sample(input logic [7:0][15:0] x, input int n);
      longint a = 0;
      for (int k = 0; k < 8; k++) a += longint'($signed(x[k])) * longint'(ctab[n][k]);
      a = (a + 64'sd8192) >>> 14;
      if (a > 32767) a = 32767;
      if (a < -32768) a = -32768;
      return int'(a);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: latency, hold-under-backpressure, scoreboard compare, done counting.
   always @(negedge clk) begin
      if (rst_n) begin
         if (coeff_valid && coeff_ready) begin
            k_acc++;
            if (k_acc == 8) begin
               acc_edge = cyc + 1;
               k_acc = 0;
            end
         end
         if (out_valid && !prev_ov) check("latency", cyc - acc_edge, 9);
         if (prev_ov && !prev_rdy) check("hold_valid", int'(out_valid), 1);
         if (out_valid) begin
            if (q_val.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_sample: got idx %0d, expected none", sample_idx);
            end else begin
               check("sample_out", int'($signed(sample_out)), q_val[0]);
               check("sample_idx", int'(sample_idx), q_idx[0]);
               if (out_ready) begin
                  void'(q_val.pop_front());
                  void'(q_idx.pop_front());
                  acc_edge = cyc + 1;
               end
            end
         end
         if (done) done_cnt++;
      end
      prev_ov  = out_valid;
      prev_rdy = out_ready;
   end

   // Downstream ready: random stalls plus a forced stall window on one sample index.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_cnt > 0 && out_valid && sample_idx == 3'(bp_target)) begin
            out_ready = 1'b0;
            bp_cnt--;
         end else begin
            out_ready = ($urandom_range(99) >= 32'(stall_pct));
         end
      end
   end

   task automatic run_block(input logic [7:0][15:0] x, input int gap, input int mode,
                            input int expv, input bit poke_start);
      int k = 0;
      int guard = 0;
      int d0;
      for (int n = 0; n < 8; n++) begin
         if (mode == 1 || (mode == 2 && n == 0)) q_val.push_back(expv);
         else q_val.push_back(ref_sample(x, n));
         q_idx.push_back(n);
      end
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (k < 8 && guard < 1000) begin
         coeff_valid = ($urandom_range(99) >= 32'(gap));
         coeff_in = coeff_valid ? x[k] : 16'($urandom);
         @(negedge clk);
         if (coeff_valid && coeff_ready) k++;
         tick();
         guard++;
      end
      check("load_complete", k, 8);
      guard = 0;
      // Garbage on coeff_valid/coeff_in while computing must not disturb X.
      while (done_cnt == d0 && guard < 3000) begin
         coeff_valid = 1'($urandom);
         coeff_in = 16'($urandom);
         start = (poke_start && guard == 20);
         tick();
         guard++;
      end
      coeff_valid = 1'b0;
      start = 1'b0;
      tick();
      tick();
      check("done_pulses", done_cnt - d0, 1);
      check("queue_drained", q_val.size(), 0);
      check("idle_after_done", int'(busy), 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_sample_out", int'(sample_out), 0);
      check("rst_sample_idx", int'(sample_idx), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_coeff_ready", int'(coeff_ready), 0);
      check("rst_done", int'(done), 0);
   endtask

   initial begin
      logic [7:0][15:0] xr;
      int guard;
      int d0;
      for (int n = 0; n < 8; n++) begin
         for (int k = 0; k < 8; k++) begin
            real c;
            real v;
            c = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
            v = 8192.0 * c * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
            ctab[n][k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
         end
      end

      tbl[0].x = '0; tbl[0].x[0] = 16'd1000; tbl[0].gap = 0; tbl[0].mode = 1;
      tbl[0].expv = 354;
      for (int k = 0; k < 8; k++) tbl[1].x[k] = 16'h7fff;
      tbl[1].gap = 0; tbl[1].mode = 2; tbl[1].expv = 32767;
      for (int k = 0; k < 8; k++) tbl[2].x[k] = 16'h8000;
      tbl[2].gap = 0; tbl[2].mode = 2; tbl[2].expv = -32768;
      for (int k = 0; k < 8; k++) tbl[3].x[k] = 16'(k * 100);
      tbl[3].gap = 40; tbl[3].mode = 0; tbl[3].expv = 0;
      for (int k = 0; k < 8; k++) tbl[4].x[k] = (k % 2 == 0) ? 16'd3000 : -16'sd2500;
      tbl[4].gap = 50; tbl[4].mode = 0; tbl[4].expv = 0;
      tbl[5].x = '0; tbl[5].x[7] = -16'sd5000; tbl[5].gap = 30; tbl[5].mode = 0;
      tbl[5].expv = 0;

      start = 1'b0;
      coeff_valid = 1'b0;
      coeff_in = 16'd0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_block(tbl[i].x, tbl[i].gap, tbl[i].mode, tbl[i].expv, 0);

      // Backpressure: 20-cycle stall on sample 3, with a start pulse while busy.
      for (int k = 0; k < 8; k++) xr[k] = 16'($urandom);
      stall_pct = 0;
      bp_target = 3;
      bp_cnt = 20;
      run_block(xr, 0, 0, 0, 1);
      check("stall_consumed", bp_cnt, 0);

      // Reset during the MAC phase of sample 2.
      for (int k = 0; k < 8; k++) xr[k] = 16'($urandom);
      for (int n = 0; n < 8; n++) begin
         q_val.push_back(ref_sample(xr, n));
         q_idx.push_back(n);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         coeff_valid = 1'b1;
         coeff_in = xr[k];
         tick();
      end
      coeff_valid = 1'b0;
      guard = 0;
      while (q_val.size() > 6 && guard < 200) begin
         tick();
         guard++;
      end
      check("reached_sample2", q_val.size(), 6);
      repeat (3) tick();
      d0 = done_cnt;
      #1 rst_n = 1'b0;
      #1 check_reset_outputs();
      q_val.delete();
      q_idx.delete();
      k_acc = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (5) tick();
      check("no_done_after_abort", done_cnt - d0, 0);
      check("waits_for_start", int'(busy), 0);
      for (int k = 0; k < 8; k++) xr[k] = 16'($urandom);
      run_block(xr, 20, 0, 0, 0);

      // Random blocks with random handshake gaps and output stalls.
      for (int b = 0; b < 150; b++) begin
         for (int k = 0; k < 8; k++) xr[k] = 16'($urandom);
         stall_pct = int'($urandom_range(50));
         run_block(xr, int'($urandom_range(60)), 0, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
